mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
Multi-lane, pipelined modular add/subtract unit with a valid-tagged pipeline, a global stall and a synchronous flush. It is the parametrised successor to the single-lane registered modular adder. It adds per-transaction add/sub mode, configurable latency and NLANE parallel lanes sharing one modulus. It sits in the NTT/RNS datapath between operand buffers and butterfly or accumulate stages.

Parameters:
BITWIDTH, 32, operand, modulus and result width per lane
NLANE, 4, number of independent lanes; all lanes share iQ and iMode
LAT, 2, pipeline latency in cycles; legal values 1..4

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  reset, asynchronous, active-low
iEn  input  1  pipeline advance; 0 = whole pipeline holds (stall)
iClr  input  1  synchronous flush of all pipeline state
iValid  input  1  operands on iData0/iData1 are a transaction
iMode  input  1  0 = (a+b) mod Q, 1 = (a-b) mod Q
iQ  input  BITWIDTH  modulus, 2 <= Q < 2^BITWIDTH; sampled with the transaction
iData0  input  NLANE*BITWIDTH  operand a, lane k at bits [k*BITWIDTH +: BITWIDTH]
iData1  input  NLANE*BITWIDTH  operand b, same packing
oValid  output  1  oData holds a new result this cycle
oData  output  NLANE*BITWIDTH  results, same packing

Behaviour:
- Reset (iRstN=0, async): all valid bits = 0, all data/Q/mode stage registers = 0.
  - Outputs during reset: oValid=0, oData=0.
- Acceptance and latency:
  - A transaction is accepted on a rising edge with iEn=1 and iValid=1.
  - Its result appears with oValid=1 exactly LAT enabled edges later.
  - Stalled (iEn=0) cycles do not count toward latency.
- Stall (iEn=0, iClr=0): every register holds, including the valid bits. oValid and oData stay unchanged; an oValid=1 result persists through the stall.
- Flush (iClr=1): on the next edge all valid bits go to 0 and all data registers go to 0, regardless of iEn. iClr has priority over iEn and iValid. In-flight transactions are dropped.
- Bubbles (iEn=1, iValid=0): a valid=0 token propagates. Data registers at a stage load only when that stage's incoming valid=1. oData therefore holds the last valid result while oValid=0.
- Arithmetic (per lane, operands required < Q):
  - Add: s = a + b at BITWIDTH+1 bits; r = (s >= Q) ? s - Q : s.
  - Sub: d = a - b at BITWIDTH+1 bits with borrow; r = borrow ? d + Q : d, truncated to BITWIDTH.
  - Out-of-range operands (>= Q): the same single conditional correction is applied and the result is truncated to BITWIDTH. No full reduction is performed.
- Stage split:
  - LAT=1: raw op and correction are combinational into the output register.
  - LAT>=2: stage 1 registers the raw sum/diff, borrow, Q and mode; stage 2 applies the correction.
  - Stages 3..LAT are pure delay registers carrying valid and result.
- iQ and iMode are captured per transaction. Changing them on any cycle does not affect transactions already in flight.
- Lanes are fully independent; there is no cross-lane carry.

Optional Feature:
MOD_ADDSUB_RANGE_CHK_EN
- Defined:
  - Adds output oErr [NLANE-1:0], reset 0.
  - Lane bit k = 1 when the transaction producing the current oData had a_k >= Q or b_k >= Q.
  - oErr is pipelined alongside the data, updates only with oValid=1, and is cleared by iClr.
- Undefined: no oErr port and no comparator logic.
- Arithmetic is identical in both builds.

Test Plan:
- Q=23, LAT=2, add, lane0 a=15 b=12, lane1 a=22 b=22 -> 2 edges later oValid=1, lane0=4, lane1=21.
- Q=23, sub, lane0 a=3 b=10, lane1 a=5 b=5, lane2 a=10 b=3 -> lane0=16, lane1=0, lane2=7.
- BITWIDTH=32, Q=0xFFFFFFFF, add, a=b=0xFFFFFFFE -> 0xFFFFFFFD; sub a=0 b=0xFFFFFFFE -> 1.
- Back-to-back stream of 100 random add/sub transactions with Q=23, then iEn=0 for 3 cycles mid-stream -> results match a (a±b) mod Q model in order, no loss or duplication, oValid/oData frozen during the stall.
- Two transactions in flight, iClr=1 for one cycle -> oValid=0 and oData=0 on the next edge, dropped results never appear, next accepted transaction returns after LAT cycles.
- iRstN pulled low mid-stream (async) -> oValid=0 and oData=0 immediately; with MOD_ADDSUB_RANGE_CHK_EN, a=30 at Q=23 -> corresponding oErr bit = 1 alongside its result.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Multi-lane pipelined modular add/subtract, shared modulus, valid-tagged stages.
// Optional per-lane operand range flags (oErr) when MOD_ADDSUB_RANGE_CHK_EN is defined.
module mod_addsub_pipe #(
  parameter int BITWIDTH = 32,
  parameter int NLANE    = 4,
  parameter int LAT      = 2
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iEn,
  input  logic                      iClr,
  input  logic                      iValid,
  input  logic                      iMode,
  input  logic [BITWIDTH-1:0]       iQ,
  input  logic [NLANE*BITWIDTH-1:0] iData0,
  input  logic [NLANE*BITWIDTH-1:0] iData1,
  output logic                      oValid,
  output logic [NLANE*BITWIDTH-1:0] oData
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic [NLANE-1:0]          oErr
`endif
);

  // Handshake: no backpressure. A transaction enters on an edge with iEn=1 and
  // iValid=1; oValid=1 marks a new result, held (with oData) while iEn=0.
  localparam int W  = BITWIDTH;
  localparam int DW = NLANE * BITWIDTH;
  localparam int RW = NLANE * (BITWIDTH + 1);
  localparam int NR = (LAT == 1) ? 1 : LAT - 1;

  function automatic logic [RW-1:0] rawOp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic mode);
    logic [RW-1:0] r;
    logic [W:0]    ak;
    logic [W:0]    bk;
    r = '0;
    for (int k = 0; k < NLANE; k++) begin
      ak = {1'b0, a[k*W +: W]};
      bk = {1'b0, b[k*W +: W]};
      r[k*(W+1) +: (W+1)] = mode ? (ak - bk) : (ak + bk);
    end
    return r;
  endfunction

  // Single conditional correction; the top raw bit is the borrow in subtract mode.
  function automatic logic [DW-1:0] correct(input logic [RW-1:0] raw, input logic [W-1:0] q,
                                            input logic mode);
    logic [DW-1:0] r;
    logic [W:0]    s;
    logic [W:0]    c;
    logic [W:0]    qx;
    r  = '0;
    qx = {1'b0, q};
    for (int k = 0; k < NLANE; k++) begin
      s = raw[k*(W+1) +: (W+1)];
      if (mode) c = s[W] ? (s + qx) : s;
      else      c = (s >= qx) ? (s - qx) : s;
      r[k*W +: W] = c[W-1:0];
    end
    return r;
  endfunction

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  function automatic logic [NLANE-1:0] rangeErr(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [W-1:0] q);
    logic [NLANE-1:0] e;
    e = '0;
    for (int k = 0; k < NLANE; k++)
      e[k] = (a[k*W +: W] >= q) || (b[k*W +: W] >= q);
    return e;
  endfunction

  logic [NLANE-1:0] headErr;
  logic [NLANE-1:0] resErr [NR];
`endif

  logic          headVld;
  logic [DW-1:0] headData;
  logic          resVld  [NR];
  logic [DW-1:0] resData [NR];

  generate
    if (LAT == 1) begin : gDirect
      assign headVld  = iValid;
      assign headData = correct(rawOp(iData0, iData1, iMode), iQ, iMode);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      assign headErr  = rangeErr(iData0, iData1, iQ);
`endif
    end else begin : gSplit
      logic          s1Vld;
      logic [RW-1:0] s1Raw;
      logic [W-1:0]  s1Q;
      logic          s1Mode;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      logic [NLANE-1:0] s1Err;
`endif
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          s1Vld  <= 1'b0;
          s1Raw  <= '0;
          s1Q    <= '0;
          s1Mode <= 1'b0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
          s1Err  <= '0;
`endif
        end else if (iClr) begin
          s1Vld  <= 1'b0;
          s1Raw  <= '0;
          s1Q    <= '0;
          s1Mode <= 1'b0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
          s1Err  <= '0;
`endif
        end else if (iEn) begin
          s1Vld <= iValid;
          if (iValid) begin
            s1Raw  <= rawOp(iData0, iData1, iMode);
            s1Q    <= iQ;
            s1Mode <= iMode;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
            s1Err  <= rangeErr(iData0, iData1, iQ);
`endif
          end
        end
      end
      assign headVld  = s1Vld;
      assign headData = correct(s1Raw, s1Q, s1Mode);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      assign headErr  = s1Err;
`endif
    end
  endgenerate

  // Result stage followed by pure delay stages; data moves only behind a valid token.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NR; i++) begin
        resVld[i]  <= 1'b0;
        resData[i] <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        resErr[i]  <= '0;
`endif
      end
    end else if (iClr) begin
      for (int i = 0; i < NR; i++) begin
        resVld[i]  <= 1'b0;
        resData[i] <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        resErr[i]  <= '0;
`endif
      end
    end else if (iEn) begin
      resVld[0] <= headVld;
      if (headVld) begin
        resData[0] <= headData;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        resErr[0]  <= headErr;
`endif
      end
      for (int i = 1; i < NR; i++) begin
        resVld[i] <= resVld[i-1];
        if (resVld[i-1]) begin
          resData[i] <= resData[i-1];
`ifdef MOD_ADDSUB_RANGE_CHK_EN
          resErr[i]  <= resErr[i-1];
`endif
        end
      end
    end
  end

  assign oValid = resVld[NR-1];
  assign oData  = resData[NR-1];
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  assign oErr   = resErr[NR-1];
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe (BITWIDTH=32, NLANE=4, LAT=2).
// Checks oErr too when MOD_ADDSUB_RANGE_CHK_EN is defined.
module tb_mod_addsub_pipe;
  localparam int W   = 32;
  localparam int NL  = 4;
  localparam int LAT = 2;
  localparam int DW  = W * NL;

  logic          iClk, iRstN, iEn, iClr, iValid, iMode;
  logic [W-1:0]  iQ;
  logic [DW-1:0] iData0, iData1;
  logic          oValid;
  logic [DW-1:0] oData;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic [NL-1:0] oErr;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];

  mod_addsub_pipe #(.BITWIDTH(W), .NLANE(NL), .LAT(LAT)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iValid(iValid), .iMode(iMode),
    .iQ(iQ), .iData0(iData0), .iData1(iData1), .oValid(oValid), .oData(oData)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    , .oErr(oErr)
`endif
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                         input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic drive(input logic vld, input logic mode, input logic [W-1:0] q,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    iValid = vld;
    iMode  = mode;
    iQ     = q;
    iData0 = a;
    iData1 = b;
  endtask

  // Reference lane result for in-range operands, computed with wide integers.
  function automatic logic [W-1:0] refLane(input longint a, input longint b, input longint q,
                                           input logic mode);
    longint r;
    r = mode ? ((a + q - b) % q) : ((a + b) % q);
    return r[W-1:0];
  endfunction

  logic [DW-1:0] sa, sb, rowExp, lastExp;
  logic          tok [LAT];
  logic          newOut, en, vld, md;
  int            txn, cyc;

  initial begin
    iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    chk("reset valid", oValid, 0);
    chk("reset data", oData, 0);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    chk("reset err", oErr, 0);
`endif
    iRstN = 1'b1; iEn = 1'b1;
    tick();

    // add, Q=23
    drive(1'b1, 1'b0, 23, pack(15, 22, 0, 0), pack(12, 22, 0, 0));
    tick();
    drive(1'b0, 1'b0, 23, '0, '0);
    chk("add latency", oValid, 0);
    tick();
    chk("add valid", oValid, 1);
    chk("add data", oData, pack(4, 21, 0, 0));
    tick();
    chk("bubble valid", oValid, 0);
    chk("bubble hold", oData, pack(4, 21, 0, 0));

    // sub, Q=23; Q/mode changed right after acceptance must not matter
    drive(1'b1, 1'b1, 23, pack(3, 5, 10, 22), pack(10, 5, 3, 0));
    tick();
    drive(1'b0, 1'b0, 5, '0, '0);
    tick();
    chk("sub valid", oValid, 1);
    chk("sub data", oData, pack(16, 0, 7, 22));

    // max modulus boundaries, back to back
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, pack(32'hFFFF_FFFE, 32'hFFFF_FFFE, 7, 0),
          pack(32'hFFFF_FFFE, 1, 9, 0));
    tick();
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, pack(0, 5, 32'hFFFF_FFFE, 0),
          pack(32'hFFFF_FFFE, 3, 0, 32'hFFFF_FFFE));
    tick();
    drive(1'b0, 1'b0, 23, '0, '0);
    chk("max add valid", oValid, 1);
    chk("max add data", oData, pack(32'hFFFF_FFFD, 0, 16, 0));
    tick();
    chk("max sub valid", oValid, 1);
    chk("max sub data", oData, pack(1, 2, 32'hFFFF_FFFE, 1));

    // stall keeps a valid result on the output
    iEn = 1'b0;
    tick(); tick();
    chk("stall valid", oValid, 1);
    chk("stall data", oData, pack(1, 2, 32'hFFFF_FFFE, 1));
    iEn = 1'b1;

    // out-of-range operand: single correction only
    drive(1'b1, 1'b0, 23, pack(20, 0, 30, 0), pack(10, 0, 1, 0));
    tick();
    drive(1'b0, 1'b0, 23, '0, '0);
    tick();
    chk("range data", oData, pack(7, 0, 8, 0));
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    chk("range err", oErr, 4'b0100);
`endif

    // flush with two transactions issued
    drive(1'b1, 1'b0, 23, pack(1, 2, 3, 4), pack(1, 1, 1, 1));
    tick();
    drive(1'b1, 1'b0, 23, pack(9, 9, 9, 9), pack(9, 9, 9, 9));
    tick();
    chk("pre-flush data", oData, pack(2, 3, 4, 5));
    iClr = 1'b1; iEn = 1'b0;
    tick();
    iClr = 1'b0; iEn = 1'b1;
    drive(1'b0, 1'b0, 23, '0, '0);
    chk("flush valid", oValid, 0);
    chk("flush data", oData, 0);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    chk("flush err", oErr, 0);
`endif
    tick();
    chk("dropped 1", oValid, 0);
    tick();
    chk("dropped 2", oValid, 0);
    drive(1'b1, 1'b0, 23, pack(10, 0, 0, 0), pack(20, 0, 0, 0));
    tick();
    drive(1'b0, 1'b0, 23, '0, '0);
    chk("post-flush latency", oValid, 0);
    tick();
    chk("post-flush valid", oValid, 1);
    chk("post-flush data", oData, pack(7, 0, 0, 0));

    // stream with scoreboard and a 3-cycle stall mid-stream
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    lastExp = '0;
    for (int k = 0; k < LAT; k++) tok[k] = 1'b0;
    txn = 0;
    cyc = 0;
    while ((txn < 100 || exp_q.size() != 0) && cyc < 400) begin
      en  = !(cyc >= 50 && cyc < 53);
      vld = (txn < 100);
      md  = (txn % 3 == 1);
      for (int k = 0; k < NL; k++) begin
        sa[k*W +: W] = W'((txn * 7 + k * 5 + 3) % 23);
        sb[k*W +: W] = W'((txn * 13 + k * 11) % 23);
        rowExp[k*W +: W] = refLane(longint'(sa[k*W +: W]), longint'(sb[k*W +: W]), 23, md);
      end
      iEn = en;
      drive(vld, md, 23, sa, sb);
      if (en && vld) begin
        exp_q.push_back(rowExp);
        txn++;
      end
      newOut = 1'b0;
      if (en) begin
        for (int k = LAT - 1; k > 0; k--) tok[k] = tok[k-1];
        tok[0] = vld;
        newOut = tok[LAT-1];
      end
      tick();
      if (newOut) begin
        chk("stream queue empty", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) lastExp = exp_q.pop_front();
      end
      chk("stream valid", oValid, tok[LAT-1]);
      chk("stream data", oData, lastExp);
      cyc++;
    end
    chk("stream count", txn, 100);
    chk("stream drained", exp_q.size(), 0);
    iEn = 1'b1;

    // async reset mid-stream
    drive(1'b1, 1'b0, 23, pack(1, 1, 1, 1), pack(2, 2, 2, 2));
    tick();
    tick();
    chk("pre-reset valid", oValid, 1);
    #2;
    iRstN = 1'b0;
    #1;
    chk("async reset valid", oValid, 0);
    chk("async reset data", oData, 0);
    tick();
    iRstN = 1'b1;
    drive(1'b0, 1'b0, 23, '0, '0);
    tick();
    chk("after reset valid", oValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
